// File: rtl/register_file.sv
// Architectural register file feeding the ALU A/B operands, including the packed
// byte operands used by the RED reduction unit.
// Two combinational read ports and one synchronous write port.
// Optional write-before-read bypass: a write is visible to reads in the same cycle.
// R0 is hardwired to zero.
//
// Ports:
//   clk       rising-edge clock
//   rst       synchronous reset, active-high; clears every register
//   SrcReg1   read port 1 index (ALU A)
//   SrcReg2   read port 2 index (ALU B)
//   DstReg    write port index
//   WriteReg  write enable
//   DstData   write data
//   SrcData1  read port 1 data (combinational)
//   SrcData2  read port 2 data (combinational)
module register_file #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 4,
  parameter bit          BYPASS = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] SrcReg1,
  input  logic [ADDR_W-1:0] SrcReg2,
  input  logic [ADDR_W-1:0] DstReg,
  input  logic              WriteReg,
  input  logic [DATA_W-1:0] DstData,
  output logic [DATA_W-1:0] SrcData1,
  output logic [DATA_W-1:0] SrcData2
);

  localparam int unsigned NREG = 1 << ADDR_W;

  logic [DATA_W-1:0] regs_q [NREG];
  logic [DATA_W-1:0] regs_d [NREG];
  logic              wr_en_c;

  // A write is effective only outside reset and never to R0.
  always_comb begin
    wr_en_c = (!rst) && WriteReg && (DstReg != '0);
  end

  // Next-state of the storage array; R0 is pinned to zero.
  always_comb begin
    regs_d = regs_q;
    if (wr_en_c) begin
      regs_d[DstReg] = DstData;
    end
    regs_d[0] = '0;
  end

  // Storage flops with synchronous reset; a write in the reset cycle is dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(NREG); i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      regs_q <= regs_d;
    end
  end

  // Read port 1: R0 forced to zero, then bypass, then stored value.
  always_comb begin
    SrcData1 = regs_q[SrcReg1];
    if (SrcReg1 == '0) begin
      SrcData1 = '0;
    end else if (BYPASS && wr_en_c && (SrcReg1 == DstReg)) begin
      SrcData1 = DstData;
    end
  end

  // Read port 2: evaluated independently of port 1.
  always_comb begin
    SrcData2 = regs_q[SrcReg2];
    if (SrcReg2 == '0) begin
      SrcData2 = '0;
    end else if (BYPASS && wr_en_c && (SrcReg2 == DstReg)) begin
      SrcData2 = DstData;
    end
  end

endmodule

// File: tb/tb_register_file.sv
// Directed bench for register_file: one bypassing instance and one non-bypassing
// instance share the same stimulus; expected values are hand-computed constants.
module tb_register_file;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned ADDR_W = 4;

  logic              clk;
  logic              rst;
  logic [ADDR_W-1:0] SrcReg1;
  logic [ADDR_W-1:0] SrcReg2;
  logic [ADDR_W-1:0] DstReg;
  logic              WriteReg;
  logic [DATA_W-1:0] DstData;
  logic [DATA_W-1:0] SrcData1;
  logic [DATA_W-1:0] SrcData2;
  logic [DATA_W-1:0] nb_SrcData1;
  logic [DATA_W-1:0] nb_SrcData2;

  int checks;
  int errors;

  register_file #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .BYPASS(1'b1)) u_dut (
    .clk      (clk),
    .rst      (rst),
    .SrcReg1  (SrcReg1),
    .SrcReg2  (SrcReg2),
    .DstReg   (DstReg),
    .WriteReg (WriteReg),
    .DstData  (DstData),
    .SrcData1 (SrcData1),
    .SrcData2 (SrcData2)
  );

  register_file #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .BYPASS(1'b0)) u_dut_nb (
    .clk      (clk),
    .rst      (rst),
    .SrcReg1  (SrcReg1),
    .SrcReg2  (SrcReg2),
    .DstReg   (DstReg),
    .WriteReg (WriteReg),
    .DstData  (DstData),
    .SrcData1 (nb_SrcData1),
    .SrcData2 (nb_SrcData2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [DATA_W-1:0] act,
                          input logic [DATA_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Advance one rising edge and settle past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    rst      = 1'b1;
    SrcReg1  = '0;
    SrcReg2  = '0;
    DstReg   = '0;
    WriteReg = 1'b0;
    DstData  = '0;

    // 1. Reset, then sweep all indices on both ports.
    tick();
    rst = 1'b0;
    for (int i = 0; i < 16; i++) begin
      SrcReg1 = ADDR_W'(i);
      SrcReg2 = ADDR_W'(15 - i);
      #1;
      check_eq($sformatf("rst_sweep_a%0d", i), SrcData1, 16'h0000);
      check_eq($sformatf("rst_sweep_b%0d", i), SrcData2, 16'h0000);
    end

    // 2. Plain write then read; neighbours untouched.
    WriteReg = 1'b1; DstReg = 4'd3; DstData = 16'h1234;
    SrcReg1 = 4'd2; SrcReg2 = 4'd4;
    #1;
    check_eq("wr_other_a", SrcData1, 16'h0000);
    check_eq("wr_other_b", SrcData2, 16'h0000);
    tick();
    WriteReg = 1'b0; SrcReg1 = 4'd3; SrcReg2 = 4'd2;
    #1;
    check_eq("wr_r3", SrcData1, 16'h1234);
    check_eq("wr_r2", SrcData2, 16'h0000);
    SrcReg2 = 4'd4;
    #1;
    check_eq("wr_r4", SrcData2, 16'h0000);
    check_eq("wr_r3_nb", nb_SrcData1, 16'h1234);

    // 3. Bypass on both ports; non-bypass instance shows the old value.
    WriteReg = 1'b1; DstReg = 4'd5; DstData = 16'hA5A5;
    SrcReg1 = 4'd5; SrcReg2 = 4'd5;
    #1;
    check_eq("byp_a", SrcData1, 16'hA5A5);
    check_eq("byp_b", SrcData2, 16'hA5A5);
    check_eq("nobyp_a_pre", nb_SrcData1, 16'h0000);
    check_eq("nobyp_b_pre", nb_SrcData2, 16'h0000);
    tick();
    WriteReg = 1'b0;
    #1;
    check_eq("byp_a_post", SrcData1, 16'hA5A5);
    check_eq("byp_b_post", SrcData2, 16'hA5A5);
    check_eq("nobyp_a_post", nb_SrcData1, 16'hA5A5);
    check_eq("nobyp_b_post", nb_SrcData2, 16'hA5A5);

    // Read and write to different registers do not interact.
    WriteReg = 1'b1; DstReg = 4'd6; DstData = 16'hBEEF;
    SrcReg1 = 4'd3; SrcReg2 = 4'd5;
    #1;
    check_eq("indep_a", SrcData1, 16'h1234);
    check_eq("indep_b", SrcData2, 16'hA5A5);
    tick();

    // 4. R0 write discarded, including under bypass.
    WriteReg = 1'b1; DstReg = 4'd0; DstData = 16'hFFFF;
    SrcReg1 = 4'd0; SrcReg2 = 4'd6;
    #1;
    check_eq("r0_pre", SrcData1, 16'h0000);
    check_eq("r6_stored", SrcData2, 16'hBEEF);
    tick();
    WriteReg = 1'b0;
    #1;
    check_eq("r0_post", SrcData1, 16'h0000);
    check_eq("r0_post_nb", nb_SrcData1, 16'h0000);

    // 5. RED operand feed.
    WriteReg = 1'b1; DstReg = 4'd1; DstData = 16'h7F80;
    tick();
    DstReg = 4'd2; DstData = 16'h0102;
    tick();
    WriteReg = 1'b0; SrcReg1 = 4'd1; SrcReg2 = 4'd2;
    #1;
    check_eq("red_a", SrcData1, 16'h7F80);
    check_eq("red_b", SrcData2, 16'h0102);

    // Back-to-back writes to one register: last edge wins.
    WriteReg = 1'b1; DstReg = 4'd9; DstData = 16'h1111;
    tick();
    DstData = 16'h2222;
    tick();
    WriteReg = 1'b0; SrcReg1 = 4'd9; SrcReg2 = 4'd9;
    #1;
    check_eq("b2b_a", SrcData1, 16'h2222);
    check_eq("b2b_b", SrcData2, 16'h2222);

    // 6. Reset mid-stream drops the concurrent write and disables bypass.
    WriteReg = 1'b1; DstReg = 4'd7; DstData = 16'h00FF;
    tick();
    rst = 1'b1; DstReg = 4'd8; DstData = 16'h0BAD;
    SrcReg1 = 4'd8; SrcReg2 = 4'd7;
    #1;
    check_eq("rst_nobyp_a", SrcData1, 16'h0000);
    check_eq("rst_stored_b", SrcData2, 16'h00FF);
    tick();
    #1;
    check_eq("rst_r8_in_rst", SrcData1, 16'h0000);
    check_eq("rst_r7_in_rst", SrcData2, 16'h0000);
    rst = 1'b0; WriteReg = 1'b0;
    #1;
    check_eq("rst_r8", SrcData1, 16'h0000);
    check_eq("rst_r7", SrcData2, 16'h0000);
    SrcReg1 = 4'd3; SrcReg2 = 4'd9;
    #1;
    check_eq("rst_r3", SrcData1, 16'h0000);
    check_eq("rst_r9", SrcData2, 16'h0000);

    // Operation resumes after reset.
    WriteReg = 1'b1; DstReg = 4'd8; DstData = 16'h0BAD;
    tick();
    WriteReg = 1'b0; SrcReg1 = 4'd8;
    #1;
    check_eq("resume_r8", SrcData1, 16'h0BAD);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
